mem_request_sequencer: RTL and testbench
========================================

// Module: mem_request_sequencer
// PURPOSE
//  CPU-side initiator for the halfword-memory interface: accepts one load/store op from the pipeline,
//  drives load/store/address/word_type/is_signed/data_in, then waits for output_valid/write_ready.
//  Returns one response (read data, error) per op on a valid/ready handshake. Per-op timeout, illegal-type
//  rejection and wrapping load/store/error counters. Sits between CPU execute stage and memory interface.
// PARAMETERS
//  ADDR_W          13  byte address width (bit 0 = byte within halfword)
//  DATA_W          32  CPU data width
//  TIMEOUT_CYCLES  16  max WAIT cycles before op is aborted with error (>=2)
//  CNT_W           16  width of status counters
// PORTS
//  clk           in   1       clock, all state on rising edge
//  reset         in   1       asynchronous, active-low reset
//  req_valid     in   1       op offered
//  req_ready     out  1       op accepted when valid&ready
//  req_is_store  in   1       1=store, 0=load
//  req_word_type in   2       00 byte, 01 halfword, 10 word, 11 illegal
//  req_signed    in   1       sign-extend loads
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   DATA_W  store data
//  rsp_valid     out  1       response available
//  rsp_ready     in   1       response consumed when valid&ready
//  rsp_rdata     out  DATA_W  load data (0 for stores/errors)
//  rsp_error     out  1       1 = illegal type or timeout
//  mi_load       out  1       load request pulse to memory interface
//  mi_store      out  1       store request pulse
//  mi_address    out  ADDR_W  held stable ISSUE..WAIT
//  mi_word_type  out  2       held stable ISSUE..WAIT
//  mi_is_signed  out  1       held stable ISSUE..WAIT
//  mi_data_in    out  DATA_W  held stable ISSUE..WAIT
//  mi_data_out   in   DATA_W  load result, valid with mi_output_valid
//  mi_output_valid in 1       load complete
//  mi_write_ready  in 1       store complete
//  mi_busy       in   1       interface occupied; no new request may be pulsed
//  load_count/store_count/error_count  out CNT_W  completed loads/stores, errors; wrap to 0
// BEHAVIOUR
//  Reset (reset=0): state IDLE; all outputs 0 incl. req_ready, counters, latched fields; immediate.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; illegal type IDLE -> RESP directly.
//  IDLE: req_ready=1. On req_valid: latch all req_* into mi_* regs; type 11 -> RESP (error=1), else ISSUE.
//  ISSUE: mi_load=!is_store&!mi_busy, mi_store=is_store&!mi_busy (combinational). If !mi_busy -> WAIT,
//   timer=0; else stay, no timeout in ISSUE. Exactly one pulse per op.
//  WAIT: load completes on mi_output_valid (capture mi_data_out); store on mi_write_ready. Completion -> RESP,
//   error=0. If no completion and timer==TIMEOUT_CYCLES-1 -> RESP, error=1, rdata=0; else timer++.
//   Completion in the timeout cycle wins. Completion strobes outside WAIT are ignored; wrong-kind strobe ignored.
//  RESP: rsp_valid=1, rsp_rdata/rsp_error stable until rsp_ready; on rsp_ready -> IDLE. req_ready=0.
//   Next op accepted earliest the cycle after the response handshake (no overlap).
//  Counters increment on entry to RESP: load_count (load ok), store_count (store ok), error_count (any error).
//  Latency: accept -> pulse 1 cycle (busy low); WAIT completion -> rsp_valid next cycle.
//  mi_* address/data regs retain last op after completion; only load/store pulses matter.
// TESTING
//  Word load 0x004; output_valid=0xDEADBEEF 3 cycles after pulse -> single mi_load pulse, rsp 0xDEADBEEF, err 0, load_count=1.
//  Byte store 0x005, data 0xA5, mi_busy high 2 cycles in ISSUE -> mi_store pulses once after busy drops; write_ready -> err 0.
//  Load, no output_valid -> rsp_error=1, rdata 0 after 16 WAIT cycles; repeat with valid in 16th WAIT cycle -> success.
//  word_type=11 -> no mi_load/mi_store, rsp_valid next cycle with error=1, error_count=1.
//  rsp_ready low 5 cycles -> rsp fields stable, req_ready=0; new req accepted cycle after handshake.
//  reset low during WAIT -> all outputs 0 same cycle; late output_valid after release ignored, state IDLE.

Source files
------------

// File: rtl/mem_request_sequencer.sv
// CPU-side initiator for the halfword memory interface.
// Takes one load/store op at a time, pulses the memory interface once,
// waits for completion or timeout, and returns one response per op.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a new op; req_ready high
// S_ISSUE | op latched; pulse mi_load/mi_store once mi_busy is low
// S_WAIT  | pulse sent; waiting for output_valid/write_ready or timeout
// S_RESP  | response held on rsp_* until rsp_ready
module mem_request_sequencer #(
  parameter int ADDR_W         = 13,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_word_type,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              mi_load,
  output logic              mi_store,
  output logic [ADDR_W-1:0] mi_address,
  output logic [1:0]        mi_word_type,
  output logic              mi_is_signed,
  output logic [DATA_W-1:0] mi_data_in,
  input  logic [DATA_W-1:0] mi_data_out,
  input  logic              mi_output_valid,
  input  logic              mi_write_ready,
  input  logic              mi_busy,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [CNT_W-1:0]  error_count
);

  // The wait timer counts down from TIMEOUT_CYCLES-1; reaching zero without
  // a completion strobe is the last allowed WAIT cycle.
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              is_store_q;
  logic [TMR_W-1:0]  timer_q;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;

  logic accept;
  logic issue_go;
  logic wait_done;
  logic wait_tmo;

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake/pulse outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mi_load   = 1'b0;
    mi_store  = 1'b0;
    accept    = 1'b0;
    issue_go  = 1'b0;
    wait_done = 1'b0;
    wait_tmo  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by reset so req_ready reads 0 for the whole reset period.
        req_ready = reset;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_word_type == 2'b11) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!mi_busy) begin
          issue_go = 1'b1;
          mi_load  = !is_store_q;
          mi_store = is_store_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Only the strobe matching the op kind completes it.
        wait_done = is_store_q ? mi_write_ready : mi_output_valid;
        if (wait_done) begin
          state_d = S_RESP;
        end else if (timer_q == '0) begin
          wait_tmo = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Op latching, wait timer, response capture and status counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_store_q   <= 1'b0;
      mi_address   <= '0;
      mi_word_type <= '0;
      mi_is_signed <= 1'b0;
      mi_data_in   <= '0;
      timer_q      <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      load_count   <= '0;
      store_count  <= '0;
      error_count  <= '0;
    end else begin
      if (accept) begin
        is_store_q   <= req_is_store;
        mi_address   <= req_addr;
        mi_word_type <= req_word_type;
        mi_is_signed <= req_signed;
        mi_data_in   <= req_wdata;
        rdata_q      <= '0;
        error_q      <= (req_word_type == 2'b11);
        if (req_word_type == 2'b11) error_count <= error_count + CNT_W'(1);
      end
      if (issue_go) timer_q <= TMR_LOAD;
      if (state_q == S_WAIT) begin
        if (wait_done) begin
          error_q <= 1'b0;
          rdata_q <= is_store_q ? '0 : mi_data_out;
          if (is_store_q) store_count <= store_count + CNT_W'(1);
          else            load_count  <= load_count + CNT_W'(1);
        end else if (wait_tmo) begin
          error_q     <= 1'b1;
          rdata_q     <= '0;
          error_count <= error_count + CNT_W'(1);
        end else begin
          timer_q <= timer_q - TMR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Randomized bench for mem_request_sequencer. A per-op reference derives the
// expected pulse cycle, response cycle, response data/error and counters from
// the op parameters (busy cycles, completion delay) with plain arithmetic.
module tb_mem_request_sequencer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int TO     = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_is_store, req_signed;
  logic [1:0]        req_word_type;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready, rsp_error;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mi_load, mi_store, mi_is_signed;
  logic [ADDR_W-1:0] mi_address;
  logic [1:0]        mi_word_type;
  logic [DATA_W-1:0] mi_data_in, mi_data_out;
  logic              mi_output_valid, mi_write_ready, mi_busy;
  logic [CNT_W-1:0]  load_count, store_count, error_count;

  int n_cmp = 0;
  int n_bad = 0;
  int m_loads = 0, m_stores = 0, m_errs = 0;

  always #5 clk = ~clk;

  mem_request_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_word_type(req_word_type), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mi_load(mi_load), .mi_store(mi_store), .mi_address(mi_address),
    .mi_word_type(mi_word_type), .mi_is_signed(mi_is_signed), .mi_data_in(mi_data_in),
    .mi_data_out(mi_data_out), .mi_output_valid(mi_output_valid),
    .mi_write_ready(mi_write_ready), .mi_busy(mi_busy),
    .load_count(load_count), .store_count(store_count), .error_count(error_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_load_count"},  load_count,  CNT_W'(m_loads));
    chk({tag, "_store_count"}, store_count, CNT_W'(m_stores));
    chk({tag, "_error_count"}, error_count, CNT_W'(m_errs));
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  // busy: cycles mi_busy is held high in ISSUE; dly: WAIT-cycle index of the
  // completion strobe (>= TO means it never arrives in time); rwait: cycles
  // rsp_ready stays low before the handshake.
  task automatic run_op(input bit st, input logic [1:0] wt, input bit sg,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input logic [DATA_W-1:0] rd_val,
                        input int busy, input int dly, input int rwait);
    bit legal, exp_err, right;
    int exp_at, cyc, first_rsp, pulse_at, n_ld, n_st, comp_cyc;
    logic [DATA_W-1:0] exp_rd;
    legal     = (wt != 2'b11);
    exp_err   = !legal || (dly >= TO);
    exp_at    = !legal ? 0 : (exp_err ? busy + 1 + TO : busy + 2 + dly);
    exp_rd    = (!exp_err && !st) ? rd_val : '0;
    comp_cyc  = busy + 1 + dly;
    first_rsp = -1;
    pulse_at  = -1;
    n_ld      = 0;
    n_st      = 0;

    req_valid     = 1'b1;
    req_is_store  = st;
    req_word_type = wt;
    req_signed    = sg;
    req_addr      = a;
    req_wdata     = wd;
    mi_busy         = 1'($urandom_range(0, 1));
    mi_output_valid = 1'($urandom_range(0, 1));
    mi_write_ready  = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    chk("rsp_valid_idle", rsp_valid, 1'b0);
    chk_counters("pre_op");
    @(posedge clk); #1;
    req_valid     = 1'b0;
    req_is_store  = 1'($urandom_range(0, 1));
    req_word_type = 2'($urandom_range(0, 3));
    req_signed    = 1'($urandom_range(0, 1));
    req_addr      = ADDR_W'($urandom);
    req_wdata     = $urandom;

    cyc = 0;
    while (first_rsp < 0 && cyc < 80) begin
      if (cyc < busy)       mi_busy = 1'b1;
      else if (cyc == busy) mi_busy = 1'b0;
      else                  mi_busy = 1'($urandom_range(0, 1));
      right = (cyc == comp_cyc) || (cyc <= busy && $urandom_range(0, 3) == 0);
      mi_data_out = (cyc == comp_cyc) ? rd_val : $urandom;
      if (st) begin
        mi_write_ready  = right;
        mi_output_valid = 1'($urandom_range(0, 1));
      end else begin
        mi_output_valid = right;
        mi_write_ready  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n_ld += int'(mi_load);
      n_st += int'(mi_store);
      if ((mi_load || mi_store) && pulse_at < 0) pulse_at = cyc;
      if (rsp_valid) first_rsp = cyc;
      if (cyc == 0) begin
        chk("mi_address",   mi_address,   a);
        chk("mi_word_type", mi_word_type, wt);
        chk("mi_is_signed", mi_is_signed, sg);
        chk("mi_data_in",   mi_data_in,   wd);
      end
      if (first_rsp < 0) chk("req_ready_busy", req_ready, 1'b0);
      @(posedge clk); #1;
      cyc++;
    end

    chk("rsp_latency", first_rsp, exp_at);
    chk("pulse_cycle", pulse_at, legal ? busy : -1);
    chk("load_pulses",  n_ld, (legal && !st) ? 1 : 0);
    chk("store_pulses", n_st, (legal && st) ? 1 : 0);

    for (int w = 0; w <= rwait; w++) begin
      rsp_ready       = (w == rwait);
      req_valid       = 1'($urandom_range(0, 1));
      mi_output_valid = 1'($urandom_range(0, 1));
      mi_write_ready  = 1'($urandom_range(0, 1));
      mi_data_out     = $urandom;
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_error", rsp_error, exp_err);
      chk("req_ready_resp", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready       = 1'b0;
    req_valid       = 1'b0;
    mi_output_valid = 1'b0;
    mi_write_ready  = 1'b0;

    if (exp_err) m_errs++;
    else if (st) m_stores++;
    else         m_loads++;
  endtask

  // Reset asserted mid-WAIT: every output drops at once, and a completion
  // strobe arriving after release must not produce a response.
  task automatic reset_in_wait();
    req_valid = 1'b1; req_is_store = 1'b0; req_word_type = 2'b10;
    req_signed = 1'b1; req_addr = 13'h1AB; req_wdata = 32'h1234_5678;
    mi_busy = 1'b0; mi_output_valid = 1'b0; mi_write_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_mi_pulses", {mi_load, mi_store}, 2'b00);
    chk("rst_mi_fields", {mi_address, mi_word_type, mi_is_signed, mi_data_in}, '0);
    m_loads = 0; m_stores = 0; m_errs = 0;
    chk_counters("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    mi_output_valid = 1'b1;
    mi_data_out = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      chk("late_valid_rsp", rsp_valid, 1'b0);
      chk("late_valid_ready", req_ready, 1'b1);
      chk("late_valid_pulse", {mi_load, mi_store}, 2'b00);
      @(posedge clk); #1;
    end
    mi_output_valid = 1'b0;
    chk_counters("post_rst");
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_word_type = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    mi_data_out = '0; mi_output_valid = 1'b0; mi_write_ready = 1'b0; mi_busy = 1'b0;

    @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_pulses", {mi_load, mi_store}, 2'b00);
    chk_counters("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Word load, output_valid three cycles after the pulse.
    run_op(1'b0, 2'b10, 1'b0, 13'h004, 32'h0, 32'hDEAD_BEEF, 0, 2, 0);
    // Byte store with mi_busy high for two ISSUE cycles.
    run_op(1'b1, 2'b00, 1'b0, 13'h005, 32'hA5, 32'h0, 2, 1, 0);
    // Load timeout, then completion on the last WAIT cycle.
    run_op(1'b0, 2'b01, 1'b1, 13'h0F0, 32'h0, 32'h1111_2222, 0, TO, 0);
    run_op(1'b0, 2'b01, 1'b1, 13'h0F2, 32'h0, 32'h3333_4444, 1, TO - 1, 0);
    // Illegal type.
    run_op(1'b0, 2'b11, 1'b0, 13'h010, 32'h0, 32'h5555_6666, 0, 0, 0);
    // Response back-pressure for five cycles.
    run_op(1'b0, 2'b10, 1'b0, 13'h020, 32'h0, 32'h7777_8888, 0, 0, 5);
    run_op(1'b1, 2'b10, 1'b0, 13'h024, 32'h9999_AAAA, 32'h0, 0, 3, 0);

    reset_in_wait();

    for (int i = 0; i < 40; i++) begin
      int r, d;
      logic [1:0] wt;
      r  = int'($urandom_range(0, 9));
      d  = (r == 0) ? TO - 1 : (r == 1) ? TO + int'($urandom_range(0, 4)) : int'($urandom_range(0, 6));
      wt = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_op(1'($urandom_range(0, 1)), wt, 1'($urandom_range(0, 1)),
             ADDR_W'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 3)), d, int'($urandom_range(0, 5)));
    end

    @(negedge clk);
    chk_counters("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
